// File: rtl/pong_game_controller_if.sv
// rtl/pong_game_controller_if.sv - controls in, game coordinates/score out
// master drives the player controls; slave is the game controller.
interface pong_game_controller_if;
  logic        frame_tick;
  logic        start;
  logic        p1_up;
  logic        p1_down;
  logic        p2_up;
  logic        p2_down;
  logic [11:0] ball_x;
  logic [11:0] ball_y;
  logic [11:0] player_1_y;
  logic [11:0] player_2_y;
  logic [3:0]  score_1;
  logic [3:0]  score_2;
  logic [1:0]  game_state;
  logic        winner;

  modport master (
    output frame_tick, start, p1_up, p1_down, p2_up, p2_down,
    input  ball_x, ball_y, player_1_y, player_2_y, score_1, score_2, game_state, winner
  );

  modport slave (
    input  frame_tick, start, p1_up, p1_down, p2_up, p2_down,
    output ball_x, ball_y, player_1_y, player_2_y, score_1, score_2, game_state, winner
  );
endinterface

// File: rtl/pong_game_controller.sv
// rtl/pong_game_controller.sv - per-frame Pong sequencer: ball, paddles, scoring, serve/play/over
// Optional BALL_SPEEDUP_EN: each paddle hit adds 1 px/tick horizontal speed up to MAX_SPEED_X.
module pong_game_controller #(
  parameter int FRAME_W      = 640,
  parameter int FRAME_H      = 480,
  parameter int BALL_SIZE    = 10,
  parameter int PLAYER_W     = 12,
  parameter int PLAYER_H     = 60,
  parameter int P1_X         = 24,
  parameter int P2_X         = 615,
  parameter int SPEED_X      = 6,
  parameter int SPEED_Y      = 2,
  parameter int PLAYER_SPEED = 4,
  parameter int SERVE_DELAY  = 60,
  parameter int WIN_SCORE    = 7,
  parameter int MAX_SPEED_X  = 12
) (
  input logic                    CLOCK_25,
  input logic                    RESET_N,
  pong_game_controller_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [11:0] K_FW         = 12'(FRAME_W);
  localparam logic [11:0] K_FH         = 12'(FRAME_H);
  localparam logic [11:0] K_BS         = 12'(BALL_SIZE);
  localparam logic [11:0] K_PH         = 12'(PLAYER_H);
  localparam logic [11:0] K_P1_FACE    = 12'(P1_X + PLAYER_W);
  localparam logic [11:0] K_P2X        = 12'(P2_X);
  localparam logic [11:0] K_SPEED_X    = 12'(SPEED_X);
  localparam logic [11:0] K_SPEED_Y    = 12'(SPEED_Y);
  localparam logic [11:0] K_PSPEED     = 12'(PLAYER_SPEED);
  localparam logic [11:0] K_SERVE_LAST = 12'(SERVE_DELAY - 1);
  localparam logic [11:0] K_CX         = 12'((FRAME_W - BALL_SIZE) / 2);
  localparam logic [11:0] K_CY         = 12'((FRAME_H - BALL_SIZE) / 2);
  localparam logic [11:0] K_PY0        = 12'((FRAME_H - PLAYER_H) / 2);
  localparam logic [11:0] K_PY_MAX     = 12'(FRAME_H - PLAYER_H);
  localparam logic [3:0]  K_WIN        = 4'(WIN_SCORE);

  if (MAX_SPEED_X < SPEED_X) begin : g_bad_speed_cfg
    $error("MAX_SPEED_X must not be below SPEED_X");
  end

  logic [1:0]  state_q, state_d;
  logic [11:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic        dir_x_q, dir_x_d;   // 1 = right
  logic        dir_y_q, dir_y_d;   // 1 = down
  logic [11:0] p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  logic [3:0]  score_1_q, score_1_d, score_2_q, score_2_d;
  logic        winner_q, winner_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] spd;
  logic        point_p1, point_p2;

`ifdef BALL_SPEEDUP_EN
  localparam logic [11:0] K_MAX_SPEED = 12'(MAX_SPEED_X);
  logic [11:0] speed_q, speed_d;
  assign spd = speed_q;
`else
  assign spd = K_SPEED_X;
`endif

  logic [11:0] b_bot, b_right;
  logic        overlap1, overlap2, hit1, hit2, miss_l, miss_r, upper1, upper2;

  assign b_bot    = ball_y_q + K_BS - 12'd1;
  assign b_right  = ball_x_q + K_BS - 12'd1;
  assign overlap1 = (b_bot >= p1_y_q) && (ball_y_q <= p1_y_q + K_PH - 12'd1);
  assign overlap2 = (b_bot >= p2_y_q) && (ball_y_q <= p2_y_q + K_PH - 12'd1);
  // A hit needs the ball to be clear of the paddle now and inside it after this step.
  assign hit2     = (b_right < K_P2X) && (b_right + spd >= K_P2X) && overlap2;
  assign hit1     = (ball_x_q >= K_P1_FACE) && (ball_x_q < K_P1_FACE + spd) && overlap1;
  assign miss_r   = (b_right + spd > K_FW - 12'd1);
  assign miss_l   = (ball_x_q < spd);
  assign upper1   = (ball_y_q + (K_BS >> 1)) < (p1_y_q + (K_PH >> 1));
  assign upper2   = (ball_y_q + (K_BS >> 1)) < (p2_y_q + (K_PH >> 1));

  function automatic logic [11:0] paddle_next(input logic [11:0] y, input logic up, input logic dn);
    if (up && !dn)      return (y < K_PSPEED) ? 12'd0 : y - K_PSPEED;
    else if (dn && !up) return (y + K_PSPEED > K_PY_MAX) ? K_PY_MAX : y + K_PSPEED;
    else                return y;
  endfunction

  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    p1_y_d    = p1_y_q;
    p2_y_d    = p2_y_q;
    score_1_d = score_1_q;
    score_2_d = score_2_q;
    winner_d  = winner_q;
    cnt_d     = cnt_q;
    point_p1  = 1'b0;
    point_p2  = 1'b0;
`ifdef BALL_SPEEDUP_EN
    speed_d   = speed_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SERVE;
          cnt_d   = '0;
        end
      end
      ST_SERVE: begin
        if (bus.frame_tick) begin
          p1_y_d = paddle_next(p1_y_q, bus.p1_up, bus.p1_down);
          p2_y_d = paddle_next(p2_y_q, bus.p2_up, bus.p2_down);
          if (cnt_q == K_SERVE_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      ST_PLAY: begin
        if (bus.frame_tick) begin
          p1_y_d = paddle_next(p1_y_q, bus.p1_up, bus.p1_down);
          p2_y_d = paddle_next(p2_y_q, bus.p2_up, bus.p2_down);
          if (dir_y_q) begin
            if (b_bot + K_SPEED_Y >= K_FH - 12'd1) begin
              ball_y_d = K_FH - K_BS;
              dir_y_d  = 1'b0;
            end else begin
              ball_y_d = ball_y_q + K_SPEED_Y;
            end
          end else begin
            if (ball_y_q < K_SPEED_Y) begin
              ball_y_d = '0;
              dir_y_d  = 1'b1;
            end else begin
              ball_y_d = ball_y_q - K_SPEED_Y;
            end
          end
          if (dir_x_q) begin
            if (hit2) begin
              ball_x_d = K_P2X - K_BS;
              dir_x_d  = 1'b0;
              dir_y_d  = !upper2;
`ifdef BALL_SPEEDUP_EN
              if (speed_q < K_MAX_SPEED) speed_d = speed_q + 12'd1;
`endif
            end else if (miss_r) begin
              point_p1 = 1'b1;
            end else begin
              ball_x_d = ball_x_q + spd;
            end
          end else begin
            if (hit1) begin
              ball_x_d = K_P1_FACE;
              dir_x_d  = 1'b1;
              dir_y_d  = !upper1;
`ifdef BALL_SPEEDUP_EN
              if (speed_q < K_MAX_SPEED) speed_d = speed_q + 12'd1;
`endif
            end else if (miss_l) begin
              point_p2 = 1'b1;
            end else begin
              ball_x_d = ball_x_q - spd;
            end
          end
          if (point_p1 || point_p2) begin
            ball_x_d = K_CX;
            ball_y_d = K_CY;
            dir_y_d  = 1'b1;
            dir_x_d  = point_p1;  // serve toward whoever conceded
            cnt_d    = '0;
`ifdef BALL_SPEEDUP_EN
            speed_d  = K_SPEED_X;
`endif
            if (point_p1) score_1_d = score_1_q + 4'd1;
            else          score_2_d = score_2_q + 4'd1;
            if ((point_p1 && score_1_q + 4'd1 == K_WIN) || (point_p2 && score_2_q + 4'd1 == K_WIN)) begin
              state_d  = ST_OVER;
              winner_d = point_p2;
            end else begin
              state_d = ST_SERVE;
            end
          end
        end
      end
      default: begin
        if (bus.start) begin
          state_d   = ST_SERVE;
          cnt_d     = '0;
          score_1_d = '0;
          score_2_d = '0;
          p1_y_d    = K_PY0;
          p2_y_d    = K_PY0;
          ball_x_d  = K_CX;
          ball_y_d  = K_CY;
          dir_x_d   = 1'b1;
          dir_y_d   = 1'b1;
`ifdef BALL_SPEEDUP_EN
          speed_d   = K_SPEED_X;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      ball_x_q  <= K_CX;
      ball_y_q  <= K_CY;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      p1_y_q    <= K_PY0;
      p2_y_q    <= K_PY0;
      score_1_q <= '0;
      score_2_q <= '0;
      winner_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      p1_y_q    <= p1_y_d;
      p2_y_q    <= p2_y_d;
      score_1_q <= score_1_d;
      score_2_q <= score_2_d;
      winner_q  <= winner_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef BALL_SPEEDUP_EN
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) speed_q <= K_SPEED_X;
    else          speed_q <= speed_d;
  end
`endif

  assign bus.ball_x     = ball_x_q;
  assign bus.ball_y     = ball_y_q;
  assign bus.player_1_y = p1_y_q;
  assign bus.player_2_y = p2_y_q;
  assign bus.score_1    = score_1_q;
  assign bus.score_2    = score_2_q;
  assign bus.game_state = state_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// tb/tb_pong_game_controller.sv - directed checks of serve, play, hits, scoring, game over, reset
// A second instance with SPEED_Y=8 shares the controls to reach the bottom wall quickly.
module tb_pong_game_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #20 clk = ~clk;

  pong_game_controller_if bus();
  pong_game_controller_if bus_fy();

  assign bus_fy.frame_tick = bus.frame_tick;
  assign bus_fy.start      = bus.start;
  assign bus_fy.p1_up      = bus.p1_up;
  assign bus_fy.p1_down    = bus.p1_down;
  assign bus_fy.p2_up      = bus.p2_up;
  assign bus_fy.p2_down    = bus.p2_down;

  pong_game_controller dut (
    .CLOCK_25 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  pong_game_controller #(.SPEED_Y(8)) dut_fy (
    .CLOCK_25 (clk),
    .RESET_N  (rst_n),
    .bus      (bus_fy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.p1_up      = 1'b0;
    bus.p1_down    = 1'b0;
    bus.p2_up      = 1'b0;
    bus.p2_down    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ball_x", bus.ball_x, 315);
    check("rst_ball_y", bus.ball_y, 235);
    check("rst_p1_y", bus.player_1_y, 210);
    check("rst_p2_y", bus.player_2_y, 210);
    check("rst_score_1", bus.score_1, 0);
    check("rst_score_2", bus.score_2, 0);
    check("rst_state", bus.game_state, 0);
    check("rst_winner", bus.winner, 0);
    rst_n = 1'b1;

    tick(2);
    check("idle_holds", bus.game_state, 0);
    pulse_start();
    check("start_serve", bus.game_state, 1);

    bus.p1_up = 1'b1; bus.p1_down = 1'b1;
    tick(5);
    check("both_keys_hold", bus.player_1_y, 210);
    bus.p1_up = 1'b0; bus.p1_down = 1'b0;
    tick(54);
    check("serve_59_state", bus.game_state, 1);
    check("serve_ball_held", bus.ball_x, 315);
    tick(1);
    check("serve_60_play", bus.game_state, 2);
    check("play_entry_ball_x", bus.ball_x, 315);
    tick(1);
    check("play1_ball_x", bus.ball_x, 321);
    check("play1_ball_y", bus.ball_y, 237);
    check("fy_play1_ball_y", bus_fy.ball_y, 243);
    tick(28);
    check("fy_play29_ball_y", bus_fy.ball_y, 467);
    tick(1);
    check("fy_bottom_clamp", bus_fy.ball_y, 470);
    tick(1);
    check("fy_bounce_up", bus_fy.ball_y, 462);
    check("play31_ball_x", bus.ball_x, 501);
    tick(21);
    check("play52_ball_x", bus.ball_x, 627);
    check("play52_state", bus.game_state, 2);
    tick(1);
    check("miss_score_1", bus.score_1, 1);
    check("miss_score_2", bus.score_2, 0);
    check("miss_state", bus.game_state, 1);
    check("miss_ball_x", bus.ball_x, 315);
    check("miss_ball_y", bus.ball_y, 235);

    bus.p2_down = 1'b1; bus.p1_up = 1'b1;
    tick(20);
    check("p2_down_20", bus.player_2_y, 290);
    bus.p2_down = 1'b0;
    tick(33);
    check("p1_up_clamp", bus.player_1_y, 0);
    tick(6);
    check("p1_up_stays", bus.player_1_y, 0);
    check("serve2_state", bus.game_state, 1);
    bus.p1_up = 1'b0;
    tick(1);
    check("serve2_play", bus.game_state, 2);
    tick(1);
    check("serve2_dir_right", bus.ball_x, 321);
    tick(47);
    check("pre_hit_ball_x", bus.ball_x, 603);
    tick(1);
    check("hit_ball_x", bus.ball_x, 605);
    check("hit_ball_y", bus.ball_y, 333);
    check("hit_score_1", bus.score_1, 1);
    tick(1);
    check("after_hit_x_left", bus.ball_x, 599);
    check("after_hit_y_down", bus.ball_y, 335);

    #5 rst_n = 1'b0;
    #1;
    check("async_rst_state", bus.game_state, 0);
    check("async_rst_ball_x", bus.ball_x, 315);
    check("async_rst_ball_y", bus.ball_y, 235);
    check("async_rst_p1_y", bus.player_1_y, 210);
    check("async_rst_p2_y", bus.player_2_y, 210);
    check("async_rst_score_1", bus.score_1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    bus.start = 1'b1; bus.frame_tick = 1'b1; bus.p1_up = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.frame_tick = 1'b0; bus.p1_up = 1'b0;
    check("start_tick_state", bus.game_state, 1);
    check("start_tick_no_move", bus.player_1_y, 210);
    tick(59);
    check("start_tick_cnt_clear", bus.game_state, 1);
    tick(1 + 53);
    check("game_pt1", bus.score_1, 1);
    for (int p = 2; p <= 7; p++) tick(113);
    check("over_state", bus.game_state, 3);
    check("over_winner", bus.winner, 0);
    check("over_score_1", bus.score_1, 7);
    check("over_score_2", bus.score_2, 0);
    tick(3);
    check("over_frozen_x", bus.ball_x, 315);
    check("over_frozen_y", bus.ball_y, 235);
    check("over_frozen_state", bus.game_state, 3);
    pulse_start();
    check("restart_state", bus.game_state, 1);
    check("restart_score_1", bus.score_1, 0);
    tick(61);
    check("restart_serve_right", bus.ball_x, 321);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
